// File: rtl/gate_pkg.sv
// Shared types for the parking-lot barrier controller.
package gate_pkg;
    typedef enum logic [2:0] {IDLE, OPENING, HOLD, PASSING, CLOSING, FAULT} gate_state_t;
    typedef enum logic {ENTRY, EXIT} dir_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Request/grant handshake between the lane card-read FSMs and the gate controller.
interface parking_gate_ctrl_if;
    logic req_in;
    logic req_out;
    logic grant_in;
    logic grant_out;

    modport master (output req_in, output req_out, input grant_in, input grant_out);
    modport slave  (input req_in, input req_out, output grant_in, output grant_out);
endinterface

// File: rtl/gate_timer.sv
// Per-state cycle counter: load sets it to 1 on state entry, so cnt_q is the
// number of cycles spent in the current state; tc flags cnt_q >= limit.
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)              cnt_d = W'(1);
        else if (clr)          cnt_d = '0;
        else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc = (cnt_q >= limit);
endmodule

// File: rtl/parking_gate_ctrl.sv
// Shared barrier sequencer: entry/exit arbitration, motor supervision, occupancy.
// Define PRIORITY_EXIT_EN to make exit always win arbitration instead of round-robin.
module parking_gate_ctrl
    import gate_pkg::*;
#(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1),
    parameter int MOVE_TO  = 50,
    parameter int HOLD_TO  = 100
) (
    input  logic              clk,
    input  logic              reset,
    parking_gate_ctrl_if.slave lane,
    input  logic              car_pass,
    input  logic              bar_up,
    input  logic              bar_down,
    input  logic              fault_clr,
    output logic              motor_open,
    output logic              motor_close,
    output logic [CNT_W-1:0]  occupancy,
    output logic              full,
    output logic              busy,
    output logic              fault
);
    localparam int TW = $clog2(max_int(MOVE_TO, HOLD_TO) + 1);

    gate_state_t      state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             grant_in_q, grant_in_d;
    logic             grant_out_q, grant_out_d;
    logic             car_pass_q, car_pass_d;
    logic             full_w, ent_ok, ex_ok, pick_exit, car_fall, tmr_tc;
    logic [TW-1:0]    tmr_limit;

    assign full_w   = (occ_q == CNT_W'(CAPACITY));
    assign ent_ok   = lane.req_in && !full_w;
    assign ex_ok    = lane.req_out && (occ_q != '0);
    assign car_fall = car_pass_q && !car_pass;

`ifdef PRIORITY_EXIT_EN
    assign pick_exit = ex_ok;
`else
    dir_t last_grant_q, last_grant_d;
    // Round-robin: exit wins a tie only if entry was served last.
    assign pick_exit = ex_ok && (!ent_ok || (last_grant_q == ENTRY));
`endif

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        occ_d       = occ_q;
        grant_in_d  = 1'b0;
        grant_out_d = 1'b0;
        car_pass_d  = car_pass;
`ifndef PRIORITY_EXIT_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: if (ent_ok || ex_ok) begin
                state_d     = OPENING;
                dir_d       = pick_exit ? EXIT : ENTRY;
                grant_out_d = pick_exit;
                grant_in_d  = !pick_exit;
`ifndef PRIORITY_EXIT_EN
                last_grant_d = pick_exit ? EXIT : ENTRY;
`endif
            end
            OPENING: begin
                if (bar_up)      state_d = HOLD;
                else if (tmr_tc) state_d = FAULT;
            end
            HOLD: begin
                if (car_pass)    state_d = PASSING;
                else if (tmr_tc) state_d = CLOSING;
            end
            PASSING: if (car_fall) begin
                state_d = CLOSING;
                if (dir_q == ENTRY) begin
                    if (occ_q != CNT_W'(CAPACITY)) occ_d = occ_q + 1'b1;
                end else begin
                    if (occ_q != '0) occ_d = occ_q - 1'b1;
                end
            end
            CLOSING: begin
                // A vehicle under a descending bar outranks the closed limit switch.
                if (car_pass)      state_d = OPENING;
                else if (bar_down) state_d = IDLE;
                else if (tmr_tc)   state_d = FAULT;
            end
            FAULT:   if (fault_clr) state_d = CLOSING;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= ENTRY;
            occ_q       <= '0;
            grant_in_q  <= 1'b0;
            grant_out_q <= 1'b0;
            car_pass_q  <= 1'b0;
`ifndef PRIORITY_EXIT_EN
            last_grant_q <= EXIT;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            occ_q       <= occ_d;
            grant_in_q  <= grant_in_d;
            grant_out_q <= grant_out_d;
            car_pass_q  <= car_pass_d;
`ifndef PRIORITY_EXIT_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign tmr_limit = (state_q == HOLD) ? TW'(HOLD_TO) : TW'(MOVE_TO);

    gate_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state_d != state_q),
        .clr   ((state_q == IDLE) || (state_q == FAULT)),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    assign lane.grant_in  = grant_in_q;
    assign lane.grant_out = grant_out_q;
    assign motor_open     = (state_q == OPENING);
    assign motor_close    = (state_q == CLOSING);
    assign occupancy      = occ_q;
    assign full           = full_w;
    assign busy           = (state_q != IDLE);
    assign fault          = (state_q == FAULT);
endmodule
